// File: rtl/text_buffer_ctrl_pkg.sv
// Shared constants and FSM state type for the Morse text-line buffer.
// Geometry is cell-based: CHAR_W x CHAR_H pixels per character cell.
package text_buffer_ctrl_pkg;

  localparam int DEPTH   = 32;
  localparam int X_START = 192;
  localparam int Y_TOP   = 208;
  localparam int CHAR_W  = 8;
  localparam int CHAR_H  = 16;

  localparam int CODE_W  = 6;
  localparam int CNT_W   = 6;
  localparam int COORD_W = 10;
  localparam int ROW_W   = 4;
  localparam int COL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/text_buffer_ctrl_if.sv
// Letter handshake, edit pulses and pixel/glyph signals of the text-line buffer.
// The master drives letters, edits and pixel coordinates; the slave is the buffer.
interface text_buffer_ctrl_if;
  import text_buffer_ctrl_pkg::*;

  logic               letter_valid;
  logic [CODE_W-1:0]  letter_num;
  logic               letter_ready;
  logic               backspace;
  logic               clear;
  logic               video_on;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [CODE_W-1:0]  rom_letter;
  logic [ROW_W-1:0]   rom_row;
  logic [COL_W-1:0]   rom_col;
  logic               pix_active;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               busy;

  modport master (
    output letter_valid, letter_num, backspace, clear, video_on, x, y,
    input  letter_ready, rom_letter, rom_row, rom_col, pix_active, count, full, busy
  );

  modport slave (
    input  letter_valid, letter_num, backspace, clear, video_on, x, y,
    output letter_ready, rom_letter, rom_row, rom_col, pix_active, count, full, busy
  );

endinterface

// File: rtl/text_buffer_ctrl_ram.sv
// Character storage for one text line: one synchronous write port, one
// asynchronous read port. Contents are deliberately not reset.
module text_line_ram #(
  parameter int DEPTH = text_buffer_ctrl_pkg::DEPTH,
  parameter int WIDTH = text_buffer_ctrl_pkg::CODE_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/text_buffer_ctrl.sv
// Text-line buffer: accepts decoded Morse letters, supports backspace and a
// sweeping clear, and serves glyph codes to the VGA path with one cycle latency.
module text_buffer_ctrl #(
  parameter int DEPTH   = text_buffer_ctrl_pkg::DEPTH,
  parameter int X_START = text_buffer_ctrl_pkg::X_START,
  parameter int Y_TOP   = text_buffer_ctrl_pkg::Y_TOP
) (
  input  logic              clk,
  input  logic              reset,
  text_buffer_ctrl_if.slave bus
);
  import text_buffer_ctrl_pkg::*;

  localparam int AW = $clog2(DEPTH);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [AW-1:0]      clr_idx_q, clr_idx_d;

  logic               we;
  logic [AW-1:0]      waddr;
  logic [CODE_W-1:0]  wdata;
  logic [AW-1:0]      raddr;
  logic [CODE_W-1:0]  rdata;

  logic               full;
  logic               ready;
  logic               accept;

  logic [10:0]        x_ext;
  logic [10:0]        y_ext;
  logic [10:0]        x_off;
  logic               hit;

  logic [CODE_W-1:0]  rom_letter_q, rom_letter_d;
  logic [ROW_W-1:0]   rom_row_q, rom_row_d;
  logic [COL_W-1:0]   rom_col_q, rom_col_d;
  logic               pix_active_q, pix_active_d;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign ready  = !reset && (state_q == IDLE) && !full && !bus.clear && !bus.backspace;
  assign accept = bus.letter_valid && ready;

  // Edit priority in IDLE is clear, then backspace, then letter accept.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    clr_idx_d = clr_idx_q;
    we        = 1'b0;
    waddr     = count_q[AW-1:0];
    wdata     = bus.letter_num;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
          count_d   = '0;
        end else if (bus.backspace) begin
          if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
          end
        end else if (accept) begin
          we      = 1'b1;
          count_d = count_q + CNT_W'(1);
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_idx_q;
        wdata = '0;
        if (bus.clear) begin
          clr_idx_d = '0;
        end else if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  text_line_ram #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Left of X_START the offset wraps far above 8*count, so one compare covers both edges.
  assign x_ext = {1'b0, bus.x};
  assign y_ext = {1'b0, bus.y};
  assign x_off = x_ext - 11'(X_START);
  assign raddr = x_off[AW+2:3];
  assign hit   = bus.video_on && (state_q == IDLE)
                 && (y_ext >= 11'(Y_TOP)) && (y_ext < 11'(Y_TOP + CHAR_H))
                 && (x_off < {2'b00, count_q, 3'b000});

  always_comb begin
    rom_letter_d = hit ? rdata : '0;
    rom_row_d    = bus.y[ROW_W-1:0];
    rom_col_d    = bus.x[COL_W-1:0];
    pix_active_d = hit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rom_letter_q <= '0;
      rom_row_q    <= '0;
      rom_col_q    <= '0;
      pix_active_q <= 1'b0;
    end else begin
      rom_letter_q <= rom_letter_d;
      rom_row_q    <= rom_row_d;
      rom_col_q    <= rom_col_d;
      pix_active_q <= pix_active_d;
    end
  end

  assign bus.letter_ready = ready;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.busy         = (state_q == CLEAR);
  assign bus.rom_letter   = rom_letter_q;
  assign bus.rom_row      = rom_row_q;
  assign bus.rom_col      = rom_col_q;
  assign bus.pix_active   = pix_active_q;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Scoreboard bench for text_buffer_ctrl: directed stimulus queues expected
// observations; negedge and accept monitors pop and compare them.
module tb_text_buffer_ctrl;
  import text_buffer_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;

  text_buffer_ctrl_if bus ();

  text_buffer_ctrl #(
    .DEPTH   (DEPTH),
    .X_START (X_START),
    .Y_TOP   (Y_TOP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {K_COUNT, K_FULL, K_BUSY, K_READY, K_LETTER, K_ROW, K_COL, K_PIX} kind_t;

  typedef struct {
    string name;
    kind_t kind;
    int    value;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;
  event sample_ev;

  task automatic check_output(input string name, input kind_t kind, input int value);
    exp_t e;
    e.name  = name;
    e.kind  = kind;
    e.value = value;
    exp_q.push_back(e);
  endtask

  function automatic int observe(input kind_t k);
    case (k)
      K_COUNT:  return int'(bus.count);
      K_FULL:   return int'(bus.full);
      K_BUSY:   return int'(bus.busy);
      K_READY:  return int'(bus.letter_ready);
      K_LETTER: return int'(bus.rom_letter);
      K_ROW:    return int'(bus.rom_row);
      K_COL:    return int'(bus.rom_col);
      K_PIX:    return int'(bus.pix_active);
      default:  return -1;
    endcase
  endfunction

  always @(negedge clk or sample_ev) begin : monitor
    exp_t e;
    int   act;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = observe(e.kind);
      n_vectors++;
      if (act != e.value) begin
        n_miscompares++;
        $display("[TB] FAIL %s: got %0d, expected %0d", e.name, act, e.value);
      end
    end
  end

  // Every accepted letter must match the next code the stimulus offered.
  always @(posedge clk) begin : accept_mon
    int want;
    if (bus.letter_valid && bus.letter_ready) begin
      n_vectors++;
      if (acc_q.size() == 0) begin
        n_miscompares++;
        $display("[TB] FAIL unexpected_accept: got letter %0d accepted, expected no accept", bus.letter_num);
      end else begin
        want = acc_q.pop_front();
        if (int'(bus.letter_num) != want) begin
          n_miscompares++;
          $display("[TB] FAIL accept_code: got %0d, expected %0d", bus.letter_num, want);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic lv, input logic [5:0] ln, input logic bs, input logic clr);
    bus.letter_valid = lv;
    bus.letter_num   = ln;
    bus.backspace    = bs;
    bus.clear        = clr;
  endtask

  task automatic set_pixel(input logic von, input logic [9:0] xx, input logic [9:0] yy);
    bus.video_on = von;
    bus.x        = xx;
    bus.y        = yy;
  endtask

  task automatic pixel_probe(input string name, input logic von, input logic [9:0] xx,
                             input logic [9:0] yy, input int letter, input int col,
                             input int row, input int pix);
    set_pixel(von, xx, yy);
    tick();
    check_output({name, "_letter"}, K_LETTER, letter);
    check_output({name, "_col"}, K_COL, col);
    check_output({name, "_row"}, K_ROW, row);
    check_output({name, "_pix"}, K_PIX, pix);
  endtask

  task automatic do_backspace(input string name, input int count_after);
    apply_stimulus(1'b0, 6'd0, 1'b1, 1'b0);
    check_output({name, "_ready"}, K_READY, 0);
    tick();
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0);
    check_output({name, "_count"}, K_COUNT, count_after);
  endtask

  int first_codes [3] = '{5, 12, 1};

  initial begin
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0);
    set_pixel(1'b1, 10'd203, 10'd210);
    #1;
    check_output("rst_count", K_COUNT, 0);
    check_output("rst_full", K_FULL, 0);
    check_output("rst_busy", K_BUSY, 0);
    check_output("rst_ready", K_READY, 0);
    check_output("rst_letter", K_LETTER, 0);
    check_output("rst_row", K_ROW, 0);
    check_output("rst_col", K_COL, 0);
    check_output("rst_pix", K_PIX, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    set_pixel(1'b0, 10'd0, 10'd0);

    // Three letters with valid held high, then the display probes.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 6'(first_codes[i]), 1'b0, 1'b0);
      if (i == 0) check_output("ready_idle", K_READY, 1);
      acc_q.push_back(first_codes[i]);
      tick();
    end
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0);
    check_output("count_three", K_COUNT, 3);
    pixel_probe("hit_cell1", 1'b1, 10'd200, 10'd210, 12, 0, 2, 1);
    pixel_probe("left_miss", 1'b1, 10'd191, 10'd210, 0, 7, 2, 0);
    pixel_probe("first_px", 1'b1, 10'd192, 10'd208, 5, 0, 0, 1);
    pixel_probe("last_px", 1'b1, 10'd215, 10'd223, 1, 7, 15, 1);
    pixel_probe("right_miss", 1'b1, 10'd216, 10'd210, 0, 0, 2, 0);
    pixel_probe("above_miss", 1'b1, 10'd200, 10'd207, 0, 0, 15, 0);
    pixel_probe("below_miss", 1'b1, 10'd200, 10'd224, 0, 0, 0, 0);
    pixel_probe("blank_miss", 1'b0, 10'd200, 10'd210, 0, 0, 2, 0);
    set_pixel(1'b1, 10'd200, 10'd210);
    check_output("latency_pre_pix", K_PIX, 0);
    tick();
    check_output("latency_post_pix", K_PIX, 1);

    // Backspace trims the visible line without touching stored codes.
    do_backspace("bs_3to2", 2);
    pixel_probe("bs_gone", 1'b1, 10'd208, 10'd210, 0, 0, 2, 0);
    pixel_probe("bs_kept", 1'b1, 10'd207, 10'd210, 12, 7, 2, 1);
    do_backspace("bs_2to1", 1);
    do_backspace("bs_1to0", 0);
    do_backspace("bs_at0", 0);

    // Fill the line, then offer a 33rd letter that must be refused.
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(1'b1, 6'(i + 1), 1'b0, 1'b0);
      acc_q.push_back(i + 1);
      tick();
    end
    apply_stimulus(1'b1, 6'd33, 1'b0, 1'b0);
    check_output("full_flag", K_FULL, 1);
    check_output("full_count", K_COUNT, 32);
    check_output("full_ready", K_READY, 0);
    tick();
    tick();
    check_output("full_hold_count", K_COUNT, 32);
    pixel_probe("full_last", 1'b1, 10'd440, 10'd210, 32, 0, 2, 1);
    pixel_probe("full_end", 1'b1, 10'd447, 10'd223, 32, 7, 15, 1);
    pixel_probe("full_past", 1'b1, 10'd448, 10'd210, 0, 0, 2, 0);
    apply_stimulus(1'b1, 6'd33, 1'b1, 1'b0);
    check_output("full_bs_ready", K_READY, 0);
    tick();
    apply_stimulus(1'b1, 6'd33, 1'b0, 1'b0);
    acc_q.push_back(33);
    check_output("unfull_count", K_COUNT, 31);
    check_output("unfull_flag", K_FULL, 0);
    check_output("unfull_ready", K_READY, 1);
    tick();
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0);
    check_output("refill_count", K_COUNT, 32);
    pixel_probe("refill_last", 1'b1, 10'd440, 10'd210, 33, 0, 2, 1);

    // Clear from count 20: 32 busy cycles with letters and backspace ignored.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(1'b0, 6'd0, 1'b1, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0);
    check_output("count_twenty", K_COUNT, 20);
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b1);
    check_output("clr_ready", K_READY, 0);
    tick();
    apply_stimulus(1'b1, 6'd7, 1'b0, 1'b0);
    set_pixel(1'b1, 10'd192, 10'd210);
    for (int k = 0; k < 32; k++) begin
      check_output("sweep_busy", K_BUSY, 1);
      check_output("sweep_ready", K_READY, 0);
      check_output("sweep_count", K_COUNT, 0);
      if (k > 0) check_output("sweep_pix", K_PIX, 0);
      if (k == 5) apply_stimulus(1'b1, 6'd7, 1'b1, 1'b0);
      if (k == 6) apply_stimulus(1'b1, 6'd7, 1'b0, 1'b0);
      if (k == 31) apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0);
      tick();
    end
    check_output("sweep_done_busy", K_BUSY, 0);
    check_output("sweep_done_ready", K_READY, 1);
    check_output("sweep_done_count", K_COUNT, 0);

    // Clear, backspace and a letter together: clear wins.
    apply_stimulus(1'b1, 6'd3, 1'b0, 1'b0);
    acc_q.push_back(3);
    tick();
    apply_stimulus(1'b1, 6'd4, 1'b0, 1'b0);
    acc_q.push_back(4);
    tick();
    check_output("prio_pre_count", K_COUNT, 2);
    apply_stimulus(1'b1, 6'd9, 1'b1, 1'b1);
    check_output("prio_ready", K_READY, 0);
    tick();
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0);
    check_output("prio_count", K_COUNT, 0);
    check_output("prio_busy", K_BUSY, 1);
    repeat (31) tick();
    check_output("prio_busy_end", K_BUSY, 1);
    tick();
    check_output("prio_idle", K_BUSY, 0);

    // A clear during the sweep restarts it from index 0.
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0);
    repeat (10) tick();
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 6'd0, 1'b0, 0);
    repeat (31) tick();
    check_output("restart_busy_held", K_BUSY, 1);
    tick();
    check_output("restart_done", K_BUSY, 0);

    // Reset mid-sweep takes effect without a clock edge.
    set_pixel(1'b1, 10'd203, 10'd210);
    tick();
    check_output("pre_rst_row", K_ROW, 2);
    check_output("pre_rst_col", K_COL, 3);
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b1);
    tick();
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0);
    repeat (10) tick();
    check_output("busy_before_rst", K_BUSY, 1);
    #5;
    reset = 1'b1;
    apply_stimulus(1'b1, 6'd20, 1'b0, 1'b0);
    #1;
    check_output("arst_busy", K_BUSY, 0);
    check_output("arst_ready", K_READY, 0);
    check_output("arst_count", K_COUNT, 0);
    check_output("arst_full", K_FULL, 0);
    check_output("arst_letter", K_LETTER, 0);
    check_output("arst_row", K_ROW, 0);
    check_output("arst_col", K_COL, 0);
    check_output("arst_pix", K_PIX, 0);
    -> sample_ev;
    tick();
    reset = 1'b0;
    acc_q.push_back(20);
    check_output("post_rst_ready", K_READY, 1);
    check_output("post_rst_busy", K_BUSY, 0);
    tick();
    apply_stimulus(1'b0, 6'd0, 1'b0, 1'b0);
    check_output("post_rst_count", K_COUNT, 1);
    pixel_probe("post_rst_cell0", 1'b1, 10'd192, 10'd210, 20, 0, 2, 1);

    tick();
    @(negedge clk);
    #1;
    n_vectors++;
    if (acc_q.size() != 0) begin
      n_miscompares++;
      $display("[TB] FAIL pending_accepts: got %0d letters never accepted, expected 0", acc_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/text_buffer_ctrl.md
TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

Interface
REQ-001 Parameter DEPTH, 32, number of character cells on the text line.
REQ-002 Parameter X_START, 192, left pixel column of cell 0.
REQ-003 Parameter Y_TOP, 208, top pixel row of the text line; line height fixed at 16 rows, cell width fixed at 8 columns.
REQ-004 clk  in  1  system clock (pixel clock domain); the only clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 letter_valid  in  1  decoder offers letter_num this cycle.
REQ-007 letter_num  in  6  letter code from the Morse decoder.
REQ-008 letter_ready  out  1  block accepts letter_num this cycle.
REQ-009 backspace  in  1  single-cycle pulse; remove the last letter.
REQ-010 clear  in  1  single-cycle pulse; erase the whole line.
REQ-011 video_on  in  1  display-active flag from the VGA sync generator.
REQ-012 x, y  in  10 each  current pixel coordinates.
REQ-013 rom_letter  out  6  letter code for the glyph ROM.
REQ-014 rom_row  out  4  glyph row (y[3:0], registered).
REQ-015 rom_col  out  3  glyph column (x[2:0], registered).
REQ-016 pix_active  out  1  current pixel lies inside an occupied cell.
REQ-017 count  out  6  number of stored letters, 0..32.
REQ-018 full  out  1  count == DEPTH.
REQ-019 busy  out  1  clear sweep in progress.

Function
REQ-020 Storage: DEPTH x 6-bit register array; one write port owned by the FSM, one read port owned by the display path.
REQ-021 FSM states: IDLE, CLEAR; IDLE->CLEAR on clear; CLEAR->IDLE the cycle after entry DEPTH-1 is written.
REQ-022 CLEAR writes code 0 to one entry per cycle, index 0..31, so a sweep lasts exactly 32 cycles; count is set to 0 on the clear cycle itself.
REQ-023 letter_ready = (state == IDLE) && !full && !clear && !backspace.
REQ-024 Handshake: a letter is accepted when letter_valid && letter_ready; it is written at index count and count increments on the same edge.
REQ-025 letter_valid with letter_ready low is not lost: the producer holds letter_num until accepted.
REQ-026 Backspace in IDLE with count > 0 decrements count by 1; with count == 0 it is ignored; stored data is not altered.
REQ-027 Priority on simultaneous pulses in IDLE: clear > backspace > letter accept.
REQ-028 backspace and letter_valid are ignored while busy; a clear during CLEAR restarts the sweep at index 0.
REQ-029 When full, letters are refused (no wrap-around); backspace and clear remain accepted.
REQ-030 Display index = (x - X_START) >> 3, 5 bits.
REQ-031 Hit = video_on && Y_TOP <= y < Y_TOP+16 && X_START <= x < X_START + 8*count; comparisons done in 11 bits, no overflow.
REQ-032 rom_letter, rom_row, rom_col, pix_active are registered: latency exactly 1 clk from x/y/video_on.
REQ-033 Outside a hit, rom_letter = 0 and pix_active = 0.
REQ-034 During CLEAR pix_active = 0.

Reset
REQ-035 reset asserted: state = IDLE, count = 0, full = 0, busy = 0, letter_ready = 0 while reset high, rom_letter = 0, rom_row = 0, rom_col = 0, pix_active = 0.
REQ-036 Storage array not reset; count = 0 masks it from the display.
REQ-037 reset mid-sweep aborts CLEAR immediately and returns to IDLE.

Structure
REQ-038 Shared package holds DEPTH, X_START, Y_TOP, CHAR_W = 8, CHAR_H = 16, and the FSM state enum.
REQ-039 One sub-module, text_line_ram (DEPTH x 6, one synchronous write port, one asynchronous read port); the FSM and the display pipeline stay in text_buffer_ctrl.

Verification
REQ-040 Accept letters 5, 12, 1 (valid held high) -> count = 3; at x = 200, y = 210, one cycle later rom_letter = 12, rom_col = 0, rom_row = 2, pix_active = 1.
REQ-041 Write 32 letters -> full = 1, letter_ready = 0; a 33rd letter_valid is not accepted and count stays 32.
REQ-042 count = 3, backspace -> count = 2; x = 208, y = 210 -> pix_active = 0; backspace at count = 0 -> count stays 0.
REQ-043 clear with count = 20 -> busy is high for exactly 32 cycles, count = 0 on the next edge, letter_ready is low throughout, then returns high.
REQ-044 clear, backspace and letter_valid in the same cycle -> clear wins: count = 0 and no letter is written.
REQ-045 reset asserted at sweep cycle 10 -> busy = 0 and every output is at its reset value immediately, without waiting for a clock edge.
